// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Optional macro BIN2BCD_BLANK_LEADING_EN blanks leading zero digits with 4'hA.
module bin2bcd_seq #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  done,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

`ifdef BIN2BCD_BLANK_LEADING_EN
  localparam logic [BCD_W-1:0] BCD_RESET = {{(DIGITS-1){4'hA}}, 4'h0};
`else
  localparam logic [BCD_W-1:0] BCD_RESET = '0;
`endif

  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [BIN_W-1:0]       sh;
  logic [BCD_W-1:0]       acc;
  logic                   ovf_pending;
  logic [BCD_W-1:0]       adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       final_bcd;

  assign in_ready = (state == S_IDLE);

  always_comb begin
    adj = acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Carry out of the top digit falls off here; overflow saturation covers it.
  assign shifted = {adj, sh} << 1;

  always_comb begin
    final_bcd = acc;
`ifdef BIN2BCD_BLANK_LEADING_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int unsigned i = DIGITS - 1; i > 0; i--) begin
        if (lead && (acc[4*i +: 4] == 4'h0)) final_bcd[4*i +: 4] = 4'hA;
        else lead = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sh          <= '0;
      acc         <= '0;
      ovf_pending <= 1'b0;
      bcd_out     <= BCD_RESET;
      overflow    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sh          <= bin_in;
            acc         <= '0;
            cnt         <= CNT_W'(BIN_W);
            ovf_pending <= (64'(bin_in) >= LIMIT);
            state       <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc <= shifted[BCD_W+BIN_W-1:BIN_W];
          sh  <= shifted[BIN_W-1:0];
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_FINISH;
        end
        S_FINISH: begin
          bcd_out  <= ovf_pending ? {DIGITS{4'h9}} : final_bcd;
          overflow <= ovf_pending;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
